cache_traffic_gen: RTL

- Programmable CPU-side request generator, directly upstream of L1_cache; drives the cpu_* request interface and replaces hand-written bench stimulus loops.
- Issues N read/write requests in one of three address modes and obeys the L1 cpu_ready handshake.
- Accumulates request, hit and latency statistics for hierarchy performance runs.

---
 rtl/cache_tg_pkg.sv | 33 +++
 rtl/cache_tg_if.sv | 24 ++
 rtl/tg_addr_gen.sv | 44 ++++
 rtl/cache_traffic_gen.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cache_tg_pkg.sv
// Shared types and helpers for the cache traffic generator.
// Address modes, FSM states, LFSR taps and saturating add.
package cache_tg_pkg;

   typedef enum logic [1:0] {
      TG_SEQ    = 2'd0,
      TG_STRIDE = 2'd1,
      TG_LFSR   = 2'd2
   } tg_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_GAP,
      ST_DONE
   } tg_state_e;

   localparam logic [15:0] TG_LFSR_TAPS = 16'hB400;

   // Clamps to the all-ones value of a w-bit counter.
   function automatic logic [63:0] sat_add(
      input logic [63:0] a,
      input logic [63:0] b,
      input int unsigned w
   );
      logic [64:0] s;
      logic [64:0] lim;
      s   = {1'b0, a} + {1'b0, b};
      lim = (65'd1 << w) - 65'd1;
      return (s > lim) ? lim[63:0] : s[63:0];
   endfunction

endpackage

// File: rtl/cache_tg_if.sv
// CPU-side request bus between the traffic generator and L1.
// master = generator, slave = cache.
interface cache_tg_if #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [DATA_WIDTH-1:0] cpu_data_in;
   logic [DATA_WIDTH-1:0] cpu_data_out;
   logic                  cpu_read;
   logic                  cpu_write;
   logic                  cpu_ready;
   logic                  l1_hit;

   modport master (
      output cpu_addr, cpu_data_in, cpu_read, cpu_write,
      input  cpu_data_out, cpu_ready, l1_hit
   );

   modport slave (
      input  cpu_addr, cpu_data_in, cpu_read, cpu_write,
      output cpu_data_out, cpu_ready, l1_hit
   );
endinterface

// File: rtl/tg_addr_gen.sv
// Address register for the traffic generator: sequential,
// stride or 16-bit Fibonacci LFSR address sequences.
module tg_addr_gen
   import cache_tg_pkg::*;
#(
   parameter int          ADDR_WIDTH = 11,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  advance,
   input  logic [1:0]            mode,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-1:0] stride,
   output logic [ADDR_WIDTH-1:0] addr
);

   logic [15:0] lfsr;
   logic [15:0] lfsr_nxt;

   assign lfsr_nxt = {lfsr[14:0], ^(lfsr & TG_LFSR_TAPS)};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr <= '0;
         lfsr <= LFSR_SEED;
      end else if (load) begin
         lfsr <= LFSR_SEED;
         addr <= (mode == TG_LFSR) ?
                 LFSR_SEED[ADDR_WIDTH-1:0] : base_addr;
      end else if (advance) begin
         unique case (mode)
            TG_STRIDE: addr <= addr + stride;
            TG_LFSR: begin
               lfsr <= lfsr_nxt;
               addr <= lfsr_nxt[ADDR_WIDTH-1:0];
            end
            default: addr <= addr + 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/cache_traffic_gen.sv
// CPU-side request generator with hit/latency statistics.
// Optional watchdog: define TG_TIMEOUT_EN.
module cache_traffic_gen
   import cache_tg_pkg::*;
#(
   parameter int          ADDR_WIDTH     = 11,
   parameter int          DATA_WIDTH     = 8,
   parameter int          CNT_WIDTH      = 32,
   parameter int          LAT_WIDTH      = 16,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1,
   parameter int          TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [1:0]            mode,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-1:0] stride,
   input  logic [CNT_WIDTH-1:0]  num_reqs,
   input  logic [7:0]            wr_period,
   cache_tg_if.master            cpu,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_WIDTH-1:0]  req_cnt,
   output logic [CNT_WIDTH-1:0]  hit_cnt,
   output logic [CNT_WIDTH-1:0]  lat_sum,
   output logic [LAT_WIDTH-1:0]  lat_max,
   output logic                  timeout
);

`ifdef TG_TIMEOUT_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   tg_state_e            state;
   logic [1:0]           mode_q;
   logic [7:0]           wrp_q;
   logic [7:0]           wcnt;
   logic [CNT_WIDTH-1:0] num_q;
   logic [LAT_WIDTH-1:0] lat;
   logic                 abort_q;

   logic                 launch;
   logic                 accept;
   logic                 fin;
   logic                 go_req;
   logic                 fire;
   logic                 is_wr;
   logic [CNT_WIDTH-1:0] idx;
   logic [7:0]           wbase;
   logic [7:0]           wsel;
   logic [7:0]           wnext;
   logic [1:0]           gen_mode;

   // Issue fields are computed for whichever request is launched next.
   always_comb begin
      launch   = (state == ST_IDLE || state == ST_DONE) && start;
      accept   = (state == ST_REQ) && cpu.cpu_ready;
      fin      = (req_cnt == num_q) || abort_q || abort;
      go_req   = (launch && num_reqs != '0) ||
                 (state == ST_GAP && !fin);
      fire     = WD_EN && (lat == LAT_WIDTH'(TIMEOUT_CYCLES));
      idx      = (state == ST_GAP) ? req_cnt + 1'b1
                                   : CNT_WIDTH'(1);
      wbase    = (state == ST_GAP) ? wcnt : 8'd0;
      wsel     = (state == ST_GAP) ? wrp_q : wr_period;
      wnext    = (wbase + 8'd1 == wsel) ? 8'd0 : wbase + 8'd1;
      is_wr    = (wsel != 8'd0) && (wnext == 8'd0);
      gen_mode = launch ? mode : mode_q;
   end

   tg_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .LFSR_SEED  (LFSR_SEED)
   ) u_addr (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (launch),
      .advance   (accept),
      .mode      (gen_mode),
      .base_addr (base_addr),
      .stride    (stride),
      .addr      (cpu.cpu_addr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         cpu.cpu_read    <= 1'b0;
         cpu.cpu_write   <= 1'b0;
         cpu.cpu_data_in <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         req_cnt         <= '0;
         hit_cnt         <= '0;
         lat_sum         <= '0;
         lat_max         <= '0;
         lat             <= '0;
         wcnt            <= '0;
         mode_q          <= '0;
         wrp_q           <= '0;
         num_q           <= '0;
         abort_q         <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  req_cnt <= '0;
                  hit_cnt <= '0;
                  lat_sum <= '0;
                  lat_max <= '0;
                  abort_q <= 1'b0;
                  mode_q  <= mode;
                  wrp_q   <= wr_period;
                  num_q   <= num_reqs;
                  state   <= ST_DONE;
                  done    <= 1'b1;
               end
            end
            ST_REQ: begin
               if (abort) abort_q <= 1'b1;
               if (accept) begin
                  req_cnt <= req_cnt + 1'b1;
                  if (cpu.l1_hit) hit_cnt <= hit_cnt + 1'b1;
                  lat_sum <= CNT_WIDTH'(sat_add(64'(lat_sum),
                             64'(lat), CNT_WIDTH));
                  if (lat > lat_max) lat_max <= lat;
                  cpu.cpu_read  <= 1'b0;
                  cpu.cpu_write <= 1'b0;
                  state         <= ST_GAP;
               end else if (fire) begin
                  cpu.cpu_read  <= 1'b0;
                  cpu.cpu_write <= 1'b0;
                  state         <= ST_DONE;
                  busy          <= 1'b0;
                  done          <= 1'b1;
               end else if (lat != '1) begin
                  lat <= lat + 1'b1;
               end
            end
            ST_GAP: begin
               if (fin) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
         if (go_req) begin
            cpu.cpu_read    <= !is_wr;
            cpu.cpu_write   <= is_wr;
            cpu.cpu_data_in <= idx[DATA_WIDTH-1:0];
            wcnt            <= wnext;
            lat             <= LAT_WIDTH'(1);
            state           <= ST_REQ;
            busy            <= 1'b1;
            done            <= 1'b0;
         end
      end
   end

`ifdef TG_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) timeout <= 1'b0;
      else if (launch) timeout <= 1'b0;
      else if (state == ST_REQ && !accept && fire) timeout <= 1'b1;
   end
`else
   assign timeout = 1'b0;
`endif

endmodule
